// File: rtl/fifo_sync_rr_drain_pkg.sv
// fifo_drain_pkg: shared sizing helpers for the round-robin FIFO drain
package fifo_drain_pkg;
    localparam int BUF_DEPTH = 2;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/fifo_sync_rr_drain_if.sv
// fifo_sync_rr_drain_if: source-FIFO side and output stream of the drain
interface fifo_sync_rr_drain_if
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) ();
    localparam int SW = clog2_min1(N);
    logic [N-1:0]       src_en;
    logic [N-1:0]       fifo_empty;
    logic [N-1:0]       fifo_rd_en;
    logic [N*WIDTH-1:0] fifo_dout;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_src;
    logic               out_valid;
    logic               out_ready;
    modport master (
        input  src_en, fifo_empty, fifo_dout, out_ready,
        output fifo_rd_en, out_data, out_src, out_valid
    );
    modport slave (
        output src_en, fifo_empty, fifo_dout, out_ready,
        input  fifo_rd_en, out_data, out_src, out_valid
    );
endinterface

// File: rtl/fifo_sync_rr_drain_arb.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr
module rr_arbiter
    import fifo_drain_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_valid
);
    logic [2*N-1:0] dbl;
    always_comb begin
        dbl = {req, req};
        for (int i = 0; i < N; i++)
            if (i <= int'(ptr)) dbl[i] = 1'b0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        // descending scan leaves the lowest set bit of the doubled vector
        for (int i = 2*N-1; i >= 0; i--)
            if (dbl[i]) begin
                gnt_idx   = SW'(i % N);
                gnt_valid = 1'b1;
            end
        gnt = gnt_valid ? N'(1) << gnt_idx : '0;
    end
endmodule

// File: rtl/fifo_sync_rr_drain.sv
// fifo_sync_rr_drain: round-robin drain of N non-FWFT FIFOs into one tagged valid/ready stream
module fifo_sync_rr_drain
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input logic clk,
    input logic rst_n,
    fifo_sync_rr_drain_if.master io
);
    localparam int SW = clog2_min1(N);
    logic [SW-1:0]    ptr, inflight_src, gnt_idx;
    logic [N-1:0]     gnt;
    logic             gnt_valid, inflight, pop, issue, wp, rp;
    logic [1:0]       occ;
    logic [2:0]       pend;
    logic [WIDTH-1:0] buf_data [BUF_DEPTH];
    logic [SW-1:0]    buf_src  [BUF_DEPTH];

    rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .req      (~io.fifo_empty & io.src_en),
        .ptr      (ptr),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    // a read is only issued when the buffer is sure to have room when its word lands
    assign pop           = io.out_valid & io.out_ready;
    assign pend          = 3'(occ) + 3'(inflight) - 3'(pop);
    assign issue         = rst_n & gnt_valid & (pend < 3'd2);
    assign io.fifo_rd_en = issue ? gnt : '0;
    assign io.out_valid  = occ != 2'd0;
    assign io.out_data   = buf_data[rp];
    assign io.out_src    = buf_src[rp];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ptr          <= SW'(N-1);
            inflight     <= 1'b0;
            inflight_src <= '0;
            occ          <= '0;
            wp           <= 1'b0;
            rp           <= 1'b0;
            buf_data     <= '{default: '0};
            buf_src      <= '{default: '0};
        end else begin
            inflight <= issue;
            if (issue) begin
                ptr          <= gnt_idx;
                inflight_src <= gnt_idx;
            end
            if (inflight) begin
                buf_data[wp] <= io.fifo_dout[inflight_src*WIDTH +: WIDTH];
                buf_src[wp]  <= inflight_src;
                wp           <= ~wp;
            end
            if (pop) rp <= ~rp;
            occ <= occ + 2'(inflight) - 2'(pop);
        end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inflight && occ == 2'd2 && !pop));
endmodule

// File: tb/tb_fifo_sync_rr_drain.sv
// tb_fifo_sync_rr_drain: scoreboard bench with source-FIFO models and a round-robin reference
module tb_fifo_sync_rr_drain;
    localparam int WIDTH = 8;
    localparam int N     = 4;

    typedef struct {
        int cyc;
        int src;
        logic [WIDTH-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_sync_rr_drain_if #(.WIDTH(WIDTH), .N(N)) io ();
    fifo_sync_rr_drain #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .rst_n(rst_n), .io(io.master));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int mptr = N-1;
    logic [WIDTH-1:0] srcq [N][$];
    ent_t sb[$];
    ent_t pop_log[$];
    int gnt_log[$];
    int gnt_cyc[$];
    logic [N-1:0] rd_q = '0;
    logic hold = 1'b0;
    logic [WIDTH-1:0] hold_data;
    int hold_src;

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference: in-order stream, RR over nonempty enabled sources, at most 2 words outstanding
    always @(negedge clk) begin
        int eg;
        logic pop;
        cyc++;
        if (!rst_n) begin
            check("reset_valid", int'(io.out_valid), 0);
            check("reset_rd_en", int'(io.fifo_rd_en), 0);
            rd_q = '0;
            sb.delete();
            mptr = N-1;
            hold = 1'b0;
        end else begin
            rd_q = io.fifo_rd_en;
            check("out_valid", int'(io.out_valid), int'(sb.size() > 0 && sb[0].cyc <= cyc-2));
            if (hold) begin
                check("stall_valid", int'(io.out_valid), 1);
                check("stall_data", int'(io.out_data), int'(hold_data));
                check("stall_src", int'(io.out_src), hold_src);
            end
            pop = io.out_valid && io.out_ready;
            if (pop) begin
                check("pop_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    check("pop_data", int'(io.out_data), int'(sb[0].data));
                    check("pop_src", int'(io.out_src), sb[0].src);
                    pop_log.push_back('{cyc, int'(io.out_src), io.out_data});
                    void'(sb.pop_front());
                end
            end
            hold = io.out_valid && !io.out_ready;
            hold_data = io.out_data;
            hold_src = int'(io.out_src);
            eg = -1;
            if (sb.size() < 2)
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (mptr + k) % N;
                    if (eg < 0 && srcq[j].size() > 0 && io.src_en[j]) eg = j;
                end
            check("rd_en", int'(io.fifo_rd_en), eg >= 0 ? (1 << eg) : 0);
            if (eg >= 0) begin
                sb.push_back('{cyc, eg, srcq[eg][0]});
                mptr = eg;
                gnt_log.push_back(eg);
                gnt_cyc.push_back(cyc);
            end
        end
    end

    // source FIFOs: non-FWFT, word appears on dout the cycle after rd_en
    task automatic src_update();
        if (rst_n)
            for (int j = 0; j < N; j++)
                if (rd_q[j]) begin
                    check("rd_nonempty", int'(srcq[j].size() > 0), 1);
                    if (srcq[j].size() > 0) io.fifo_dout[j*WIDTH +: WIDTH] = srcq[j].pop_front();
                end
        for (int j = 0; j < N; j++) io.fifo_empty[j] = (srcq[j].size() == 0);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            src_update();
        end
    endtask

    task automatic load(int i, logic [WIDTH-1:0] d);
        srcq[i].push_back(d);
        io.fifo_empty[i] = 1'b0;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        gnt_cyc.delete();
        pop_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("async_valid", int'(io.out_valid), 0);
        check("async_rd_en", int'(io.fifo_rd_en), 0);
        tick(2);
        clear_logs();
        rst_n = 1'b1;
    endtask

    initial begin
        int pat[3];
        int left;
        pat = '{0, 1, 3};
        io.src_en = '1;
        io.out_ready = 1'b1;
        io.fifo_dout = '0;
        io.fifo_empty = '1;
        tick(3);
        rst_n = 1'b1;

        tick(20);
        check("t1_reads", gnt_log.size(), 0);
        check("t1_pops", pop_log.size(), 0);

        clear_logs();
        for (int k = 0; k < 3; k++) load(0, 8'hA0 + 8'(k));
        tick(8);
        check("t2_reads", gnt_log.size(), 3);
        check("t2_pops", pop_log.size(), 3);
        for (int k = 0; k < 3 && k < gnt_log.size() && k < pop_log.size(); k++) begin
            check("t2_gnt", gnt_log[k], 0);
            check("t2_gnt_cyc", gnt_cyc[k], gnt_cyc[0] + k);
            check("t2_latency", pop_log[k].cyc, gnt_cyc[k] + 2);
            check("t2_data", int'(pop_log[k].data), 'hA0 + k);
            check("t2_src", pop_log[k].src, 0);
        end

        tick();
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 2; k++) load(i, 8'(16*i + k));
        tick(14);
        check("t3_reads", gnt_log.size(), 8);
        check("t3_pops", pop_log.size(), 8);
        for (int k = 0; k < 8 && k < gnt_log.size() && k < pop_log.size(); k++) begin
            check("t3_gnt", gnt_log[k], k % 4);
            check("t3_pop_cyc", pop_log[k].cyc, pop_log[0].cyc + k);
        end

        do_reset();
        io.out_ready = 1'b0;
        load(1, 8'h11); load(1, 8'h12); load(3, 8'h31); load(3, 8'h32);
        tick(10);
        check("t4_reads", gnt_log.size(), 2);
        check("t4_head_valid", int'(io.out_valid), 1);
        check("t4_head_data", int'(io.out_data), 'h11);
        io.out_ready = 1'b1;
        tick(8);
        check("t4_reads_after", gnt_log.size(), 4);
        check("t4_pops", pop_log.size(), 4);
        for (int k = 0; k < 4 && k < gnt_log.size() && k < pop_log.size(); k++) begin
            check("t4_gnt", gnt_log[k], k % 2 ? 3 : 1);
            check("t4_pop_src", pop_log[k].src, k % 2 ? 3 : 1);
        end

        do_reset();
        io.src_en = 4'b1011;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++) load(i, 8'($urandom));
        tick(16);
        check("t5_reads", gnt_log.size(), 9);
        for (int k = 0; k < 9 && k < gnt_log.size(); k++) check("t5_gnt", gnt_log[k], pat[k % 3]);
        io.src_en = '1;
        tick(10);

        do_reset();
        for (int k = 0; k < 6; k++) load(0, 8'h60 + 8'(k));
        load(3, 8'h70); load(3, 8'h71);
        left = 10;
        while (!io.out_valid && left > 0) begin
            tick();
            left--;
        end
        check("t6_valid_seen", int'(io.out_valid), 1);
        do_reset();
        tick(6);
        check("t6_first_gnt", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
        tick(20);

        for (int c = 0; c < 2000; c++) begin
            tick();
            for (int i = 0; i < N; i++)
                if (srcq[i].size() < 6 && $urandom_range(0, 2) == 0) load(i, 8'($urandom));
            if ($urandom_range(0, 15) == 0) io.src_en = 4'($urandom);
            io.out_ready = $urandom_range(0, 3) != 0;
        end
        io.src_en = '1;
        io.out_ready = 1'b1;
        tick(80);
        check("drain_sb_empty", sb.size(), 0);
        left = 0;
        for (int i = 0; i < N; i++) left += srcq[i].size();
        check("drain_src_empty", left, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
